uart_tx_basic: RTL
==================

UART_TX_BASIC -- requirements
Module: uart_tx_basic

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87 (10 MHz / 115200 baud), giving clock cycles per serial bit; legal range >= 2.
REQ-002 SHALL have port i_Clock  input  1  single system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_Rst_L  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_Tx_DV  input  1  one-cycle request to send i_Tx_Byte.
REQ-005 SHALL have port i_Tx_Byte  input  8  byte to transmit, sampled only on an accepted request.
REQ-006 SHALL have port o_Tx_Active  output  1  high while a frame is on the line.
REQ-007 SHALL have port o_Tx_Serial  output  1  serial line, idles high.
REQ-008 SHALL have port o_Tx_Done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-009 SHALL use the frame format 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), with no parity.
REQ-010 SHALL implement states IDLE, START, DATA, STOP and CLEANUP.
REQ-011 In IDLE, o_Tx_Serial SHALL be 1, o_Tx_Active SHALL be 0, and the bit-clock counter and bit index SHALL be 0.
REQ-012 A request SHALL be accepted on a rising edge where the state is IDLE and i_Tx_DV=1; on that edge i_Tx_Byte is latched, the state goes to START, o_Tx_Serial goes to 0 and o_Tx_Active goes to 1.
REQ-013 Each bit (start, each data bit, stop) SHALL drive o_Tx_Serial for exactly CLKS_PER_BIT cycles, timed by a counter running 0..CLKS_PER_BIT-1 that resets to 0 on each bit change.
REQ-014 In DATA, bit index 0..7 SHALL select the latched byte; the transition to STOP SHALL occur after index 7 completes.
REQ-015 Bit index wrap SHALL occur as follows: after index 7 the index returns to 0 and the state goes to STOP.
REQ-016 At the end of STOP, the state SHALL go to CLEANUP, o_Tx_Active SHALL go to 0 and o_Tx_Done SHALL go to 1 for exactly one cycle.
REQ-017 CLEANUP SHALL last 1 cycle and then go to IDLE, with o_Tx_Serial held at 1.
REQ-018 Total frame time, from the accept edge to o_Tx_Done rising, SHALL be 10*CLKS_PER_BIT cycles.
REQ-019 The next request SHALL be accepted no earlier than 2 cycles after o_Tx_Done rises.
REQ-020 i_Tx_DV asserted in any state other than IDLE SHALL be ignored and not queued; the frame in progress SHALL be unaffected.
REQ-021 Changes to i_Tx_Byte after the accept edge SHALL have no effect on the frame in progress.
REQ-022 The bit-clock counter SHALL be $clog2(CLKS_PER_BIT) bits wide with no overflow; the bit index SHALL be 3 bits wide.
REQ-023 o_Tx_Serial SHALL be driven from a register, with no combinational path from any input.

Reset
REQ-024 On i_Rst_L=0, at any time and including mid-frame, the block SHALL immediately go to IDLE with o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, counters at 0 and the latched byte at 0x00.
REQ-025 A frame interrupted by reset SHALL NOT resume, and o_Tx_Done SHALL NOT pulse for it.
REQ-026 The first request SHALL be accepted on the first rising edge after i_Rst_L is deasserted where i_Tx_DV=1.

Structure
REQ-027 State encodings (3-bit) and the default CLKS_PER_BIT SHALL live in a shared UART definitions include file, also used by uart_rx_basic.
REQ-028 No sub-module SHALL be used; the baud counter stays inline. An optional uart_tx_basic_tb loopback harness SHALL instantiate uart_tx_basic together with uart_rx_basic.

Verification
REQ-029 With a 100 ns clock and CLKS_PER_BIT=87, sending i_Tx_Byte=0xAB SHALL produce the line sequence 0,1,1,0,1,0,1,0,1,1, each bit held 87 cycles, with o_Tx_Done 870 cycles after accept.
REQ-030 In loopback of o_Tx_Serial into uart_rx_basic, sending 0x3F SHALL give o_Rx_Byte=0x3F; sending 0x00 and then 0xFF back-to-back, with each request issued 2 cycles after the previous o_Tx_Done, SHALL give both bytes received correctly.
REQ-031 Pulsing i_Tx_DV with 0x55 at cycle 100 of a 0xAB frame SHALL leave the 0xAB waveform intact and send no second frame.
REQ-032 Changing i_Tx_Byte from 0xAB to 0x12 one cycle after accept SHALL still transmit 0xAB.
REQ-033 Asserting i_Rst_L=0 during data bit 3 SHALL make o_Tx_Serial=1 and o_Tx_Active=0 immediately, with no o_Tx_Done pulse; a request after release SHALL send a correct full frame.
REQ-034 With CLKS_PER_BIT=2 and 0x80 sent, the frame SHALL be 20 cycles long and the last data bit SHALL be 1 for exactly 2 cycles.

Source files
------------

// File: rtl/uart_tx_basic_pkg.sv
// Shared UART definitions: transmitter state encodings and default bit timing.
`timescale 1ns/1ps
package uart_tx_basic_pkg;

  // 10 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_basic_if.sv
// Byte-request / serial-status bundle between a byte producer and uart_tx_basic.
`timescale 1ns/1ps
interface uart_tx_basic_if;

  // Handshake: tx_dv is a one-cycle request that carries tx_byte. It is taken
  // only while the transmitter is idle; otherwise it is dropped, not queued.
  // There is no ready line: a producer waits until two cycles after tx_done
  // rises (or until tx_active is low and the block is idle) before requesting.
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_serial;
  logic       tx_done;

  modport master (
    output tx_dv,
    output tx_byte,
    input  tx_active,
    input  tx_serial,
    input  tx_done
  );

  modport slave (
    input  tx_dv,
    input  tx_byte,
    output tx_active,
    output tx_serial,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_basic.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit, then a
// one-cycle cleanup with a done pulse. All outputs come straight from flops.
`timescale 1ns/1ps
module uart_tx_basic
  import uart_tx_basic_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done,
  output tx_state_t  o_Dbg_State
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_MAX = 3'(UART_DATA_BITS - 1);

  tx_state_t        state,   state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       tx_byte, tx_byte_nxt;
  logic             serial_nxt;
  logic             active_nxt;
  logic             done_nxt;
  logic             bit_end;

  assign bit_end     = (clk_cnt == CNT_MAX);
  assign o_Dbg_State = state;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= ST_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      tx_byte     <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      tx_byte     <= tx_byte_nxt;
      o_Tx_Serial <= serial_nxt;
      o_Tx_Active <= active_nxt;
      o_Tx_Done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    tx_byte_nxt = tx_byte;
    case (state)
      ST_IDLE: begin
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (i_Tx_DV) begin
          tx_byte_nxt = i_Tx_Byte;
          state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          state_nxt   = ST_DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (bit_idx == IDX_MAX) begin
            bit_idx_nxt = '0;
            state_nxt   = ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          state_nxt   = ST_CLEANUP;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      ST_CLEANUP: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each flop changes on the same
  // edge as the state it reflects.
  always_comb begin
    serial_nxt = 1'b1;
    active_nxt = 1'b0;
    done_nxt   = 1'b0;
    case (state_nxt)
      ST_START: begin
        serial_nxt = 1'b0;
        active_nxt = 1'b1;
      end
      ST_DATA: begin
        serial_nxt = tx_byte_nxt[bit_idx_nxt];
        active_nxt = 1'b1;
      end
      ST_STOP:    active_nxt = 1'b1;
      ST_CLEANUP: done_nxt   = 1'b1;
      default:    ;
    endcase
  end

endmodule
